// File: rtl/warp_fetch_sched.sv
// -----------------------------------------------------------------------------
// warp_fetch_sched
//
// Per-core warp fetch scheduler. Keeps one program counter and one active bit
// per warp, picks one eligible warp per cycle in round-robin order and presents
// a registered (warp id, PC) fetch request to the instruction cache under a
// valid/ready handshake. Warps can be launched, halted and redirected; each
// warp can be masked from selection through warp_stall.
//
// Ports
//   clk             clock
//   reset           asynchronous, active-high reset
//   start_valid     launch warp start_id at start_pc
//   start_id        warp to launch
//   start_pc        launch PC
//   halt_valid      deactivate warp halt_id
//   halt_id         warp to halt
//   redirect_valid  branch/jump redirect of warp redirect_id to redirect_pc
//   redirect_id     redirected warp (ignored if that warp is inactive)
//   redirect_pc     redirect target
//   warp_stall      per-warp "do not fetch" mask, sampled in the selection cycle
//   fetch_valid     fetch request valid (registered)
//   fetch_ready     icache accepts the request
//   fetch_warp_id   requesting warp (registered)
//   fetch_pc        fetch address (registered)
//   active_mask     registered active bit per warp
// -----------------------------------------------------------------------------
module warp_fetch_sched #(
    parameter int                    NUM_WARPS    = 4,
    parameter int                    PC_WIDTH     = 32,
    parameter logic [PC_WIDTH-1:0]   RESET_PC     = '0,
    parameter logic [PC_WIDTH-1:0]   FETCH_STRIDE = PC_WIDTH'(4),
    parameter logic [NUM_WARPS-1:0]  RESET_ACTIVE = NUM_WARPS'(1),
    localparam int                   WID_W        = $clog2(NUM_WARPS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_valid,
    input  logic [WID_W-1:0]      start_id,
    input  logic [PC_WIDTH-1:0]   start_pc,
    input  logic                  halt_valid,
    input  logic [WID_W-1:0]      halt_id,
    input  logic                  redirect_valid,
    input  logic [WID_W-1:0]      redirect_id,
    input  logic [PC_WIDTH-1:0]   redirect_pc,
    input  logic [NUM_WARPS-1:0]  warp_stall,
    output logic                  fetch_valid,
    input  logic                  fetch_ready,
    output logic [WID_W-1:0]      fetch_warp_id,
    output logic [PC_WIDTH-1:0]   fetch_pc,
    output logic [NUM_WARPS-1:0]  active_mask
);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [PC_WIDTH-1:0]                 pc_reg [NUM_WARPS];
    logic [NUM_WARPS-1:0][PC_WIDTH-1:0]  pc_next;
    logic [NUM_WARPS-1:0]                active_reg;
    logic [NUM_WARPS-1:0]                active_next;
    logic [WID_W-1:0]                    rr_ptr_reg;
    logic [WID_W-1:0]                    rr_ptr_next;

    logic                                fetch_valid_reg;
    logic                                fetch_valid_next;
    logic [WID_W-1:0]                    fetch_warp_id_reg;
    logic [WID_W-1:0]                    fetch_warp_id_next;
    logic [PC_WIDTH-1:0]                 fetch_pc_reg;
    logic [PC_WIDTH-1:0]                 fetch_pc_next;

    // -------------------------------------------------------------------------
    // Per-warp event decode
    // -------------------------------------------------------------------------
    logic [NUM_WARPS-1:0] start_hit;
    logic [NUM_WARPS-1:0] halt_hit;
    logic [NUM_WARPS-1:0] redirect_hit;
    logic [NUM_WARPS-1:0] kill_this_cycle;
    logic [NUM_WARPS-1:0] eligible;
    logic [NUM_WARPS-1:0] grant;

    logic                 load;
    logic                 kill_held;
    logic                 winner_found;
    logic [WID_W-1:0]     winner;

    generate
        for (genvar gi = 0; gi < NUM_WARPS; gi++) begin : g_warp
            assign start_hit[gi]    = start_valid && (start_id == WID_W'(gi));
            assign halt_hit[gi]     = halt_valid && (halt_id == WID_W'(gi));
            // A redirect to a warp that is not running has no effect at all,
            // so it must not kill anything either.
            assign redirect_hit[gi] = redirect_valid && (redirect_id == WID_W'(gi))
                                      && active_reg[gi];

            assign kill_this_cycle[gi] = start_hit[gi] | halt_hit[gi] | redirect_hit[gi];

            // A warp touched by an event this cycle waits one cycle so its
            // fetch always uses the post-event PC.
            assign eligible[gi] = active_reg[gi] & ~warp_stall[gi] & ~kill_this_cycle[gi];

            assign grant[gi] = load && !kill_held && winner_found && (winner == WID_W'(gi));

            // Start overrides redirect; halt leaves the PC alone. A granted
            // warp can never carry an event this cycle (it would not be
            // eligible), so the increment never collides with a write.
            assign pc_next[gi] = start_hit[gi]    ? start_pc :
                                 redirect_hit[gi] ? redirect_pc :
                                 grant[gi]        ? pc_reg[gi] + FETCH_STRIDE :
                                                    pc_reg[gi];

            // Start beats halt on the same warp.
            assign active_next[gi] = start_hit[gi] ? 1'b1 :
                                     halt_hit[gi]  ? 1'b0 :
                                                     active_reg[gi];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Handshake control
    // -------------------------------------------------------------------------
    assign load = ~fetch_valid_reg | fetch_ready;

    // A request stuck on the output for a warp whose PC or state changes this
    // cycle is stale; drop it. If ready is high the transfer completes anyway.
    assign kill_held = fetch_valid_reg & ~fetch_ready & kill_this_cycle[fetch_warp_id_reg];

    // -------------------------------------------------------------------------
    // Round-robin search starting just after the last granted warp
    // -------------------------------------------------------------------------
    always_comb begin
        logic [WID_W-1:0] cand;
        winner_found = 1'b0;
        winner       = '0;
        cand         = '0;
        for (int i = 1; i <= NUM_WARPS; i++) begin
            cand = WID_W'((int'(rr_ptr_reg) + i) % NUM_WARPS);
            if (!winner_found && eligible[cand]) begin
                winner_found = 1'b1;
                winner       = cand;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Output register / pointer next-state
    // -------------------------------------------------------------------------
    always_comb begin
        fetch_valid_next   = fetch_valid_reg;
        fetch_warp_id_next = fetch_warp_id_reg;
        fetch_pc_next      = fetch_pc_reg;
        rr_ptr_next        = rr_ptr_reg;

        if (kill_held) begin
            fetch_valid_next = 1'b0;
        end else if (load) begin
            if (winner_found) begin
                fetch_valid_next   = 1'b1;
                fetch_warp_id_next = winner;
                fetch_pc_next      = pc_reg[winner];
                rr_ptr_next        = winner;
            end else begin
                fetch_valid_next = 1'b0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                pc_reg[w] <= RESET_PC;
            end
            active_reg        <= RESET_ACTIVE;
            rr_ptr_reg        <= WID_W'(NUM_WARPS - 1);
            fetch_valid_reg   <= 1'b0;
            fetch_warp_id_reg <= '0;
            fetch_pc_reg      <= '0;
        end else begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                pc_reg[w] <= pc_next[w];
            end
            active_reg        <= active_next;
            rr_ptr_reg        <= rr_ptr_next;
            fetch_valid_reg   <= fetch_valid_next;
            fetch_warp_id_reg <= fetch_warp_id_next;
            fetch_pc_reg      <= fetch_pc_next;
        end
    end

    assign fetch_valid   = fetch_valid_reg;
    assign fetch_warp_id = fetch_warp_id_reg;
    assign fetch_pc      = fetch_pc_reg;
    assign active_mask   = active_reg;

endmodule

// File: tb/tb_warp_fetch_sched.sv
// -----------------------------------------------------------------------------
// tb_warp_fetch_sched
//
// Directed bench for warp_fetch_sched with NUM_WARPS=4, PC_WIDTH=32,
// RESET_PC=0, FETCH_STRIDE=4, RESET_ACTIVE=0001. Each task drives one
// scenario and compares registered outputs 1 time unit after the rising edge
// against hand-computed values.
// -----------------------------------------------------------------------------
module tb_warp_fetch_sched;

    logic        clk;
    logic        reset;
    logic        start_valid;
    logic [1:0]  start_id;
    logic [31:0] start_pc;
    logic        halt_valid;
    logic [1:0]  halt_id;
    logic        redirect_valid;
    logic [1:0]  redirect_id;
    logic [31:0] redirect_pc;
    logic [3:0]  warp_stall;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [1:0]  fetch_warp_id;
    logic [31:0] fetch_pc;
    logic [3:0]  active_mask;

    int tests_run    = 0;
    int tests_failed = 0;

    warp_fetch_sched #(
        .NUM_WARPS    (4),
        .PC_WIDTH     (32),
        .RESET_PC     (32'h0),
        .FETCH_STRIDE (32'h4),
        .RESET_ACTIVE (4'b0001)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start_valid    (start_valid),
        .start_id       (start_id),
        .start_pc       (start_pc),
        .halt_valid     (halt_valid),
        .halt_id        (halt_id),
        .redirect_valid (redirect_valid),
        .redirect_id    (redirect_id),
        .redirect_pc    (redirect_pc),
        .warp_stall     (warp_stall),
        .fetch_valid    (fetch_valid),
        .fetch_ready    (fetch_ready),
        .fetch_warp_id  (fetch_warp_id),
        .fetch_pc       (fetch_pc),
        .active_mask    (active_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start_valid    = 1'b0;
        start_id       = '0;
        start_pc       = '0;
        halt_valid     = 1'b0;
        halt_id        = '0;
        redirect_valid = 1'b0;
        redirect_id    = '0;
        redirect_pc    = '0;
        warp_stall     = '0;
        fetch_ready    = 1'b1;
    endtask

    // Reset for two edges, release 1 unit after an edge; the next step() is
    // the first edge out of reset.
    task automatic apply_reset();
        idle_inputs();
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        logic [31:0] exp_pc [3] = '{32'h0, 32'h4, 32'h8};
        idle_inputs();
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        tests_run++;
        if (fetch_valid !== 1'b0 || fetch_warp_id !== 2'd0 || fetch_pc !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_out: got v=%0b w=%0d pc=%h, want v=0 w=0 pc=00000000",
                     fetch_valid, fetch_warp_id, fetch_pc);
        end
        tests_run++;
        if (active_mask !== 4'b0001) begin
            tests_failed++;
            $display("FAIL reset_mask: got %b, want 0001", active_mask);
        end
        $display("[TB] reset: v=%0b mask=%b", fetch_valid, active_mask);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            tests_run++;
            if (fetch_valid !== 1'b1 || fetch_warp_id !== 2'd0 || fetch_pc !== exp_pc[k]) begin
                tests_failed++;
                $display("FAIL reset_stream[%0d]: got v=%0b w=%0d pc=%h, want v=1 w=0 pc=%h",
                         k, fetch_valid, fetch_warp_id, fetch_pc, exp_pc[k]);
            end
            $display("[TB] reset_stream[%0d]: w=%0d pc=%h", k, fetch_warp_id, fetch_pc);
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_round_robin();
        logic [1:0]  exp_id [7] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0};
        logic [31:0] exp_pc [7] = '{32'h0, 32'h100, 32'h200, 32'h4, 32'h104, 32'h204, 32'h8};
        apply_reset();
        for (int k = 0; k < 7; k++) begin
            if (k == 0) begin
                start_valid = 1'b1; start_id = 2'd1; start_pc = 32'h100;
            end else if (k == 1) begin
                start_valid = 1'b1; start_id = 2'd2; start_pc = 32'h200;
            end else begin
                start_valid = 1'b0;
            end
            step();
            tests_run++;
            if (fetch_valid !== 1'b1 || fetch_warp_id !== exp_id[k] || fetch_pc !== exp_pc[k]) begin
                tests_failed++;
                $display("FAIL rr[%0d]: got v=%0b w=%0d pc=%h, want v=1 w=%0d pc=%h",
                         k, fetch_valid, fetch_warp_id, fetch_pc, exp_id[k], exp_pc[k]);
            end
            $display("[TB] rr[%0d]: w=%0d pc=%h", k, fetch_warp_id, fetch_pc);
        end
    endtask

    // Continues from test_round_robin: output holds (w0,0x8), rr at w0.
    task automatic test_backpressure();
        logic [1:0]  exp_id [3] = '{2'd1, 2'd2, 2'd0};
        logic [31:0] exp_pc [3] = '{32'h108, 32'h208, 32'hC};
        fetch_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            tests_run++;
            if (fetch_valid !== 1'b1 || fetch_warp_id !== 2'd0 || fetch_pc !== 32'h8) begin
                tests_failed++;
                $display("FAIL hold[%0d]: got v=%0b w=%0d pc=%h, want v=1 w=0 pc=00000008",
                         k, fetch_valid, fetch_warp_id, fetch_pc);
            end
            $display("[TB] hold[%0d]: w=%0d pc=%h", k, fetch_warp_id, fetch_pc);
        end
        fetch_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            tests_run++;
            if (fetch_valid !== 1'b1 || fetch_warp_id !== exp_id[k] || fetch_pc !== exp_pc[k]) begin
                tests_failed++;
                $display("FAIL release[%0d]: got v=%0b w=%0d pc=%h, want v=1 w=%0d pc=%h",
                         k, fetch_valid, fetch_warp_id, fetch_pc, exp_id[k], exp_pc[k]);
            end
            $display("[TB] release[%0d]: w=%0d pc=%h", k, fetch_warp_id, fetch_pc);
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_redirect();
        apply_reset();
        start_valid = 1'b1; start_id = 2'd1; start_pc = 32'h100;
        step();                              // (w0,0x0)
        start_valid = 1'b0;
        step();                              // (w1,0x100)
        fetch_ready    = 1'b0;
        redirect_valid = 1'b1; redirect_id = 2'd1; redirect_pc = 32'h400;
        step();
        tests_run++;
        if (fetch_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL redir_kill: got v=%0b, want v=0", fetch_valid);
        end
        $display("[TB] redir_kill: v=%0b", fetch_valid);
        redirect_valid = 1'b0;
        fetch_ready    = 1'b1;
        step();
        tests_run++;
        if (fetch_valid !== 1'b1 || fetch_warp_id !== 2'd0 || fetch_pc !== 32'h4) begin
            tests_failed++;
            $display("FAIL redir_next: got v=%0b w=%0d pc=%h, want v=1 w=0 pc=00000004",
                     fetch_valid, fetch_warp_id, fetch_pc);
        end
        step();
        tests_run++;
        if (fetch_valid !== 1'b1 || fetch_warp_id !== 2'd1 || fetch_pc !== 32'h400) begin
            tests_failed++;
            $display("FAIL redir_target: got v=%0b w=%0d pc=%h, want v=1 w=1 pc=00000400",
                     fetch_valid, fetch_warp_id, fetch_pc);
        end
        $display("[TB] redir_target: w=%0d pc=%h", fetch_warp_id, fetch_pc);
        // Same redirect while ready is high: the w1 request completes normally.
        redirect_valid = 1'b1; redirect_id = 2'd1; redirect_pc = 32'h800;
        step();
        tests_run++;
        if (fetch_valid !== 1'b1 || fetch_warp_id !== 2'd0 || fetch_pc !== 32'h8) begin
            tests_failed++;
            $display("FAIL redir_ready: got v=%0b w=%0d pc=%h, want v=1 w=0 pc=00000008",
                     fetch_valid, fetch_warp_id, fetch_pc);
        end
        redirect_valid = 1'b0;
        step();
        tests_run++;
        if (fetch_valid !== 1'b1 || fetch_warp_id !== 2'd1 || fetch_pc !== 32'h800) begin
            tests_failed++;
            $display("FAIL redir_ready_target: got v=%0b w=%0d pc=%h, want v=1 w=1 pc=00000800",
                     fetch_valid, fetch_warp_id, fetch_pc);
        end
        $display("[TB] redir_ready_target: w=%0d pc=%h", fetch_warp_id, fetch_pc);
    endtask

    // -------------------------------------------------------------------------
    task automatic test_stall();
        logic [1:0]  exp_id [9] = '{2'd3, 2'd0, 2'd2, 2'd3, 2'd0, 2'd2, 2'd3, 2'd0, 2'd1};
        logic [31:0] exp_pc [9] = '{32'h300, 32'h4, 32'h204, 32'h304, 32'h8,
                                   32'h208, 32'h308, 32'hC, 32'h104};
        apply_reset();
        start_valid = 1'b1; start_id = 2'd1; start_pc = 32'h100;
        step();                              // (w0,0x0)
        start_id = 2'd2; start_pc = 32'h200;
        step();                              // (w1,0x100)
        start_id = 2'd3; start_pc = 32'h300;
        step();                              // (w2,0x200)
        start_valid = 1'b0;
        warp_stall  = 4'b0010;
        for (int k = 0; k < 9; k++) begin
            if (k == 6) warp_stall = 4'b0000;
            step();
            tests_run++;
            if (fetch_valid !== 1'b1 || fetch_warp_id !== exp_id[k] || fetch_pc !== exp_pc[k]) begin
                tests_failed++;
                $display("FAIL stall[%0d]: got v=%0b w=%0d pc=%h, want v=1 w=%0d pc=%h",
                         k, fetch_valid, fetch_warp_id, fetch_pc, exp_id[k], exp_pc[k]);
            end
            $display("[TB] stall[%0d]: w=%0d pc=%h", k, fetch_warp_id, fetch_pc);
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_edge_cases();
        apply_reset();
        start_valid = 1'b1; start_id = 2'd3; start_pc = 32'hFFFF_FFFC;
        step();                              // (w0,0x0)
        start_valid = 1'b0;
        step();
        tests_run++;
        if (fetch_valid !== 1'b1 || fetch_warp_id !== 2'd3 || fetch_pc !== 32'hFFFF_FFFC) begin
            tests_failed++;
            $display("FAIL wrap_hi: got v=%0b w=%0d pc=%h, want v=1 w=3 pc=fffffffc",
                     fetch_valid, fetch_warp_id, fetch_pc);
        end
        step();                              // (w0,0x4)
        step();
        tests_run++;
        if (fetch_valid !== 1'b1 || fetch_warp_id !== 2'd3 || fetch_pc !== 32'h0) begin
            tests_failed++;
            $display("FAIL wrap_zero: got v=%0b w=%0d pc=%h, want v=1 w=3 pc=00000000",
                     fetch_valid, fetch_warp_id, fetch_pc);
        end
        $display("[TB] wrap: w=%0d pc=%h", fetch_warp_id, fetch_pc);

        // Halt and start on w2 together: start wins.
        halt_valid  = 1'b1; halt_id  = 2'd2;
        start_valid = 1'b1; start_id = 2'd2; start_pc = 32'h500;
        step();
        tests_run++;
        if (fetch_warp_id !== 2'd0 || fetch_pc !== 32'h8 || active_mask !== 4'b1101) begin
            tests_failed++;
            $display("FAIL halt_start: got w=%0d pc=%h mask=%b, want w=0 pc=00000008 mask=1101",
                     fetch_warp_id, fetch_pc, active_mask);
        end
        halt_valid  = 1'b0;
        start_valid = 1'b0;
        step();
        tests_run++;
        if (fetch_valid !== 1'b1 || fetch_warp_id !== 2'd2 || fetch_pc !== 32'h500) begin
            tests_failed++;
            $display("FAIL halt_start_pc: got v=%0b w=%0d pc=%h, want v=1 w=2 pc=00000500",
                     fetch_valid, fetch_warp_id, fetch_pc);
        end
        $display("[TB] halt_start: w=%0d pc=%h mask=%b", fetch_warp_id, fetch_pc, active_mask);

        // Halt w3, then redirect it while inactive: nothing should revive it.
        halt_valid = 1'b1; halt_id = 2'd3;
        step();
        tests_run++;
        if (fetch_warp_id !== 2'd0 || fetch_pc !== 32'hC || active_mask !== 4'b0101) begin
            tests_failed++;
            $display("FAIL halt_w3: got w=%0d pc=%h mask=%b, want w=0 pc=0000000c mask=0101",
                     fetch_warp_id, fetch_pc, active_mask);
        end
        halt_valid     = 1'b0;
        redirect_valid = 1'b1; redirect_id = 2'd3; redirect_pc = 32'h900;
        step();
        tests_run++;
        if (fetch_warp_id !== 2'd2 || fetch_pc !== 32'h504) begin
            tests_failed++;
            $display("FAIL redir_inactive_a: got w=%0d pc=%h, want w=2 pc=00000504",
                     fetch_warp_id, fetch_pc);
        end
        redirect_valid = 1'b0;
        step();
        tests_run++;
        if (fetch_warp_id !== 2'd0 || fetch_pc !== 32'h10 || active_mask !== 4'b0101) begin
            tests_failed++;
            $display("FAIL redir_inactive_b: got w=%0d pc=%h mask=%b, want w=0 pc=00000010 mask=0101",
                     fetch_warp_id, fetch_pc, active_mask);
        end
        step();
        tests_run++;
        if (fetch_warp_id !== 2'd2 || fetch_pc !== 32'h508) begin
            tests_failed++;
            $display("FAIL redir_inactive_c: got w=%0d pc=%h, want w=2 pc=00000508",
                     fetch_warp_id, fetch_pc);
        end
        $display("[TB] redir_inactive: w=%0d pc=%h mask=%b", fetch_warp_id, fetch_pc, active_mask);
    endtask

    // -------------------------------------------------------------------------
    task automatic test_async_reset();
        apply_reset();
        start_valid = 1'b1; start_id = 2'd1; start_pc = 32'h100;
        step();                              // (w0,0x0)
        start_valid = 1'b0;
        step();                              // (w1,0x100)
        fetch_ready = 1'b0;
        step();                              // held (w1,0x100)
        #2;
        reset = 1'b1;
        #1;
        tests_run++;
        if (fetch_valid !== 1'b0 || fetch_warp_id !== 2'd0 || fetch_pc !== 32'h0
            || active_mask !== 4'b0001) begin
            tests_failed++;
            $display("FAIL async_reset: got v=%0b w=%0d pc=%h mask=%b, want v=0 w=0 pc=00000000 mask=0001",
                     fetch_valid, fetch_warp_id, fetch_pc, active_mask);
        end
        $display("[TB] async_reset: v=%0b mask=%b", fetch_valid, active_mask);
        step();
        reset = 1'b0;
        fetch_ready = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_round_robin();
        test_backpressure();
        test_redirect();
        test_stall();
        test_edge_cases();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/warp_fetch_sched.md
# warp_fetch_sched

Per-core warp fetch scheduler: holds one program counter and one active bit per warp, picks one eligible warp per cycle round-robin, and issues a registered (warp id, PC) fetch request to the instruction cache under a valid/ready handshake. Sits at the head of the core pipeline, replacing the single-stride per-warp PC bank. It adds:
- warp launch/halt,
- branch redirect,
- per-warp stall masking,
- backpressure.

## Interface
- NUM_WARPS, 4, warps per core (≥2); WID_W = $clog2(NUM_WARPS)
- PC_WIDTH, 32, program-counter width
- RESET_PC, 0, PC value of every warp after reset
- FETCH_STRIDE, 4, PC increment per issued fetch
- RESET_ACTIVE, 'b1, active mask after reset (warp 0 running)

- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- start_valid  in  1  launch a warp
- start_id  in  WID_W  warp to launch
- start_pc  in  PC_WIDTH  launch PC
- halt_valid  in  1  deactivate a warp
- halt_id  in  WID_W  warp to halt
- redirect_valid  in  1  branch/jump redirect
- redirect_id  in  WID_W  redirected warp
- redirect_pc  in  PC_WIDTH  redirect target
- warp_stall  in  NUM_WARPS  per-warp "do not fetch" (scoreboard/ibuffer full)
- fetch_valid  out  1  request valid
- fetch_ready  in  1  icache accepts request
- fetch_warp_id  out  WID_W  requesting warp
- fetch_pc  out  PC_WIDTH  fetch address
- active_mask  out  NUM_WARPS  registered active bits

## Operation
- State:
  - pc[NUM_WARPS]
  - active[NUM_WARPS]
  - rr_ptr (last granted, WID_W)
  - output register {fetch_valid, fetch_warp_id, fetch_pc}
- Reset:
  - every pc = RESET_PC
  - active = RESET_ACTIVE
  - rr_ptr = NUM_WARPS-1, so warp 0 wins first
  - fetch_valid = 0, fetch_warp_id = 0, fetch_pc = 0
- Eligible[w] = active[w] & ~warp_stall[w] & ~kill_this_cycle[w]. kill_this_cycle[w] is redirect, halt or start addressed to w this cycle.
- Load condition: load = ~fetch_valid | fetch_ready.
  - If load and any warp is eligible: winner = first eligible searching rr_ptr+1, rr_ptr+2, … modulo NUM_WARPS.
  - On a winner: fetch_warp_id ← winner, fetch_pc ← pc[winner], pc[winner] ← pc[winner] + FETCH_STRIDE, rr_ptr ← winner, fetch_valid ← 1.
  - If load and nothing is eligible: fetch_valid ← 0.
- Hold: while fetch_valid & ~fetch_ready, fetch_warp_id and fetch_pc stay stable, except on kill (below).
- Start: active[start_id] ← 1, pc[start_id] ← start_pc.
- Halt: active[halt_id] ← 0.
- Redirect: applies only if active[redirect_id]; redirect to an inactive warp is ignored. Effect: pc[redirect_id] ← redirect_pc.
- Kill: a held request whose fetch_warp_id matches an applied redirect, halt or start is dropped (fetch_valid ← 0), unless fetch_ready is high that cycle.
  - If fetch_ready is high, the handoff completes and downstream discards it via its own redirect tracking.
  - On a kill, no new winner is loaded that cycle.
- Same-warp conflicts, same cycle:
  - start beats halt and redirect
  - halt beats redirect
- Different-warp events in the same cycle are all applied.
- PC arithmetic is modulo 2^PC_WIDTH; 2^PC_WIDTH − FETCH_STRIDE wraps to 0. PC alignment is not checked.

## Timing
- Request latency: an eligible warp sampled at edge N appears on fetch_valid/fetch_pc after edge N (registered output). There is no combinational path from any input to any output.
- Throughput: one request per cycle while fetch_ready stays high and ≥1 warp is eligible.
- Start, halt and redirect take effect at the next edge. The affected warp becomes eligible one cycle after the event at the earliest.
- active_mask reflects the registered active bits (one cycle after start/halt).
- warp_stall is sampled combinationally in the selection cycle. Asserting it does not withdraw an already-registered request.
- Reset asserted mid-handshake clears fetch_valid immediately (asynchronous). The in-flight request is lost.

## Test plan
- Reset, RESET_ACTIVE='b1, fetch_ready=1:
  - fetch_valid rises one cycle after reset release
  - stream is (w0,0x0),(w0,0x4),(w0,0x8)…
  - active_mask=0001
- Start w1@0x100, w2@0x200 with w0 active, ready=1:
  - round-robin issue w0,w1,w2,w0…
  - each warp's PC advances by 4 only on its own grants
- fetch_ready=0 for 5 cycles:
  - warp id/PC held constant
  - no PC advances
  - on release, the held request is accepted and the next warp in RR order follows
- Redirect w1→0x400 while w1's request is held with ready=0:
  - request dropped
  - w1 next fetches 0x400
  - repeat with ready=1 in the same cycle: handoff completes, then 0x400
- warp_stall=0010 with all four warps active:
  - w1 never granted
  - others rotate w0,w2,w3
  - deasserting the stall restores w1 in RR order
- Edge cases:
  - start w3@0xFFFFFFFC: fetches 0xFFFFFFFC then 0x0
  - halt+start to w2 in the same cycle: w2 active with the new PC
  - redirect to inactive w3: ignored, pc[w3] unchanged
